// File: rtl/srio_ireq_dispatcher_if.sv
// AXI4-Stream ireq bundle with P_N parallel lanes; lane n occupies slice n of each vector.
// The dispatcher uses one lane upstream and P_CHAN_NUM lanes toward the SRIO channels.
interface srio_ireq_dispatcher_if #(
  parameter int P_N = 1
);
  logic [P_N-1:0]    tvalid;
  logic [P_N-1:0]    tready;
  logic [P_N-1:0]    tlast;
  logic [64*P_N-1:0] tdata;
  logic [8*P_N-1:0]  tkeep;
  logic [32*P_N-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/srio_ireq_dispatcher.sv
// Packet-atomic dispatcher of one ireq AXIS stream across P_CHAN_NUM SRIO channels.
// Optional macro SRIO_DISPATCH_DROP_EN: unroutable packets in P_MODE=1 are discarded and counted.
module srio_ireq_dispatcher #(
  parameter int P_CHAN_NUM = 4,
  parameter int P_MODE     = 0,
  parameter int P_CNT_W    = 16
) (
  input  logic                          i_log_clk,
  input  logic                          i_rst,
  input  logic [P_CHAN_NUM-1:0]         i_port_initialized,
  srio_ireq_dispatcher_if.slave         s_axis_ireq,
  srio_ireq_dispatcher_if.master        m_axis_ireq,
  output logic [P_CNT_W*P_CHAN_NUM-1:0] o_pkt_cnt,
  output logic [15:0]                   o_drop_cnt,
  output logic                          o_busy
);

  localparam int SEL_W = (P_CHAN_NUM > 1) ? $clog2(P_CHAN_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [SEL_W-1:0]                   sel_q, sel_d;
  logic [SEL_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [P_CHAN_NUM-1:0][P_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             tgt_in_range;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= P_CHAN_NUM) sum = sum - P_CHAN_NUM;
    return SEL_W'(sum);
  endfunction

  // Target for the packet waiting in IDLE: next live channel after rr_ptr, or the tuser dest index.
  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    tgt          = '0;
    tgt_ok       = 1'b0;
    tgt_in_range = 1'b0;
    if (P_MODE == 0) begin
      for (int i = 1; i <= P_CHAN_NUM; i++) begin
        if (!tgt_ok && i_port_initialized[wrap_add(rr_ptr_q, i)]) begin
          tgt    = wrap_add(rr_ptr_q, i);
          tgt_ok = 1'b1;
        end
      end
    end else begin
      tgt          = s_axis_ireq.tuser[SEL_W-1:0];
      tgt_in_range = (int'(tgt) < P_CHAN_NUM);
      tgt_ok       = tgt_in_range && i_port_initialized[tgt];
    end
  end

`ifdef SRIO_DISPATCH_DROP_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
`ifdef SRIO_DISPATCH_DROP_EN
    drop_cnt_d = drop_cnt_q;
`endif
    s_axis_ireq.tready = 1'b0;
    m_axis_ireq.tvalid = '0;
    m_axis_ireq.tlast  = '0;
    m_axis_ireq.tdata  = '0;
    m_axis_ireq.tkeep  = '0;
    m_axis_ireq.tuser  = '0;

    case (state_q)
      // Upstream is never ready here: the first beat waits one cycle while the channel is chosen.
      ST_IDLE: begin
        if (s_axis_ireq.tvalid[0]) begin
          if (tgt_ok) begin
            sel_d   = tgt;
            state_d = ST_SEND;
            if (P_MODE == 0) rr_ptr_d = tgt;
          end
`ifdef SRIO_DISPATCH_DROP_EN
          else if (P_MODE != 0) begin
            state_d = ST_DROP;
          end
`endif
        end
      end

      // Pass-through ignores link state so a packet is never cut once started.
      ST_SEND: begin
        m_axis_ireq.tvalid[sel_q]          = s_axis_ireq.tvalid[0];
        m_axis_ireq.tlast[sel_q]           = s_axis_ireq.tlast[0];
        m_axis_ireq.tdata[64*sel_q +: 64]  = s_axis_ireq.tdata[63:0];
        m_axis_ireq.tkeep[8*sel_q +: 8]    = s_axis_ireq.tkeep[7:0];
        m_axis_ireq.tuser[32*sel_q +: 32]  = s_axis_ireq.tuser[31:0];
        s_axis_ireq.tready                 = m_axis_ireq.tready[sel_q];
        if (s_axis_ireq.tvalid[0] && m_axis_ireq.tready[sel_q] && s_axis_ireq.tlast[0]) begin
          pkt_cnt_d[sel_q] = pkt_cnt_q[sel_q] + 1'b1;
          state_d          = ST_IDLE;
        end
      end

`ifdef SRIO_DISPATCH_DROP_EN
      ST_DROP: begin
        s_axis_ireq.tready = 1'b1;
        if (s_axis_ireq.tvalid[0] && s_axis_ireq.tlast[0]) begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_log_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

`ifdef SRIO_DISPATCH_DROP_EN
  always_ff @(posedge i_log_clk) begin
    if (i_rst) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_pkt_cnt = pkt_cnt_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
